seq_recognizer_fsm: RTL and testbench

- Parametrised Moore sequence recognizer. Successor to the fixed 8-state, two-sequence, 3-symbol recognizer.
- Detects any of NUM_SEQ_G programmable sequences of SEQ_LEN_G symbols on a valid-qualified symbol stream.
- Adds a per-symbol valid qualifier, an inter-symbol timeout, a match ID, and a saturating error counter.
- Sits after the link symbol decoder in TMR-hardened control paths. The next-state logic is a separate combinational sub-module so it can be kept or triplicated.

---
 rtl/seq_recognizer_pkg.sv | 40 ++++
 rtl/seq_rec_next_state.sv | 93 +++++++++
 rtl/seq_recognizer_fsm.sv | 121 ++++++++++++
 tb/tb_seq_recognizer_fsm.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_recognizer_pkg.sv
// Shared types and helpers for the programmable sequence recognizer.
// Holds the state encoding and the header lookup used by the next-state logic.
package seq_recognizer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    DONE   = 2'b10,
    ERROR  = 2'b11
  } state_e;

  localparam state_e RESET_STATE_C   = IDLE;
  localparam state_e DEFAULT_STATE_C = ERROR;

  localparam int MAX_SEQ_C    = 8;
  localparam int MAX_DATA_W_C = 32;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } hdr_match_t;

  typedef logic [MAX_SEQ_C-1:0][MAX_DATA_W_C-1:0] hdr_tbl_t;

  // Lowest-index header equal to sym; headers are distinct so at most one hits.
  function automatic hdr_match_t match_header(input hdr_tbl_t                 hdrs,
                                              input int unsigned              num,
                                              input logic [MAX_DATA_W_C-1:0] sym);
    hdr_match_t res;
    res = '0;
    for (int unsigned i = 0; i < MAX_SEQ_C; i++) begin
      if (i < num && !res.hit && hdrs[i] == sym) begin
        res.hit = 1'b1;
        res.idx = 3'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_rec_next_state.sv
// Purely combinational next-state logic of the sequence recognizer, kept
// separate so it can be preserved or triplicated on its own.
module seq_rec_next_state
  import seq_recognizer_pkg::*;
#(
  parameter int DATA_W_G  = 3,
  parameter int NUM_SEQ_G = 2,
  parameter int SEQ_LEN_G = 3,
  parameter logic [0:NUM_SEQ_G-1][0:SEQ_LEN_G-1][DATA_W_G-1:0] SEQ_TABLE_G =
    {{3'd1, 3'd2, 3'd3}, {3'd4, 3'd5, 3'd6}},
  parameter logic [DATA_W_G-1:0] IDLE_SYM_G = '0,
  parameter int SEQ_W_G = 1,
  parameter int POS_W_G = 2
) (
  (* dont_touch = "true" *) input  state_e              state_i,
  (* dont_touch = "true" *) input  logic [SEQ_W_G-1:0]  seq_id_i,
  (* dont_touch = "true" *) input  logic [POS_W_G-1:0]  pos_i,
  (* dont_touch = "true" *) input  logic                timeout_hit_i,
  (* dont_touch = "true" *) input  logic [DATA_W_G-1:0] data_i,
  (* dont_touch = "true" *) input  logic                valid_i,
  (* dont_touch = "true" *) output state_e              state_d_o,
  (* dont_touch = "true" *) output logic [SEQ_W_G-1:0]  seq_id_d_o,
  (* dont_touch = "true" *) output logic [POS_W_G-1:0]  pos_d_o
);

  localparam logic [POS_W_G-1:0] LAST_POS_C = POS_W_G'(SEQ_LEN_G - 1);

  hdr_tbl_t   hdrs;
  hdr_match_t hm;

  always_comb begin
    hdrs = '0;
    for (int k = 0; k < NUM_SEQ_G; k++) begin
      hdrs[k] = MAX_DATA_W_C'(SEQ_TABLE_G[k][0]);
    end
    hm = match_header(hdrs, NUM_SEQ_G, MAX_DATA_W_C'(data_i));
  end

  always_comb begin
    state_d_o  = state_i;
    seq_id_d_o = seq_id_i;
    pos_d_o    = pos_i;
    case (state_i)
      IDLE: begin
        if (valid_i && hm.hit) begin
          state_d_o  = ACTIVE;
          seq_id_d_o = SEQ_W_G'(hm.idx);
          pos_d_o    = POS_W_G'(1);
        end
      end
      ACTIVE: begin
        if (timeout_hit_i) begin
          state_d_o = ERROR;
          pos_d_o   = '0;
        end else if (valid_i) begin
          if (data_i == SEQ_TABLE_G[seq_id_i][pos_i]) begin
            if (pos_i == LAST_POS_C) begin
              state_d_o = DONE;
              pos_d_o   = '0;
            end else begin
              pos_d_o = pos_i + 1'b1;
            end
          end else begin
            state_d_o = ERROR;
            pos_d_o   = '0;
          end
        end
      end
      DONE: begin
        // A new header here chains straight into the next sequence.
        if (valid_i) begin
          if (data_i == IDLE_SYM_G) begin
            state_d_o = IDLE;
          end else if (hm.hit) begin
            state_d_o  = ACTIVE;
            seq_id_d_o = SEQ_W_G'(hm.idx);
            pos_d_o    = POS_W_G'(1);
          end else begin
            state_d_o = ERROR;
          end
        end
      end
      ERROR: begin
        state_d_o = IDLE;
      end
      default: begin
        state_d_o = DEFAULT_STATE_C;
        pos_d_o   = '0;
      end
    endcase
  end

endmodule

// File: rtl/seq_recognizer_fsm.sv
// Moore recognizer for NUM_SEQ_G programmable symbol sequences with
// timeout, match ID and a saturating error counter.
module seq_recognizer_fsm
  import seq_recognizer_pkg::*;
#(
  parameter int DATA_W_G  = 3,
  parameter int NUM_SEQ_G = 2,
  parameter int SEQ_LEN_G = 3,
  parameter logic [0:NUM_SEQ_G-1][0:SEQ_LEN_G-1][DATA_W_G-1:0] SEQ_TABLE_G =
    {{3'd1, 3'd2, 3'd3}, {3'd4, 3'd5, 3'd6}},
  parameter logic [DATA_W_G-1:0] IDLE_SYM_G = '0,
  parameter int TIMEOUT_G   = 4,
  parameter int ERR_CNT_W_G = 8,
  localparam int SEQ_W_C = (NUM_SEQ_G > 1) ? $clog2(NUM_SEQ_G) : 1,
  localparam int POS_W_C = $clog2(SEQ_LEN_G)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DATA_W_G-1:0]    data_i,
  input  logic                   data_valid_i,
  input  logic                   clear_cnt_i,
  output logic [1:0]             state_o,
  output logic [SEQ_W_C-1:0]     seq_id_o,
  output logic [POS_W_C-1:0]     pos_o,
  output logic                   match_o,
  output logic                   error_o,
  output logic [ERR_CNT_W_G-1:0] err_cnt_o
);

  localparam int TO_W_C = (TIMEOUT_G > 0) ? $clog2(TIMEOUT_G + 1) : 1;
  localparam logic [TO_W_C-1:0] TO_LAST_C = TO_W_C'(TIMEOUT_G - 1);

  if (SEQ_LEN_G < 2) begin : g_len_chk
    $error("SEQ_LEN_G must be at least 2");
  end
  if (DATA_W_G > MAX_DATA_W_C || NUM_SEQ_G < 1 || NUM_SEQ_G > MAX_SEQ_C) begin : g_size_chk
    $error("DATA_W_G or NUM_SEQ_G out of supported range");
  end
  for (genvar a = 0; a < NUM_SEQ_G; a++) begin : g_hdr_chk
    if (SEQ_TABLE_G[a][0] == IDLE_SYM_G) begin : g_idle
      $error("a sequence header equals IDLE_SYM_G");
    end
    for (genvar b = a + 1; b < NUM_SEQ_G; b++) begin : g_dup
      if (SEQ_TABLE_G[a][0] == SEQ_TABLE_G[b][0]) begin : g_err
        $error("sequence headers are not distinct");
      end
    end
  end

  state_e                 state_q, state_d;
  logic [SEQ_W_C-1:0]     seq_id_q, seq_id_d;
  logic [POS_W_C-1:0]     pos_q, pos_d;
  logic                   match_q, match_d;
  logic [ERR_CNT_W_G-1:0] err_cnt_q, err_cnt_d;
  logic [TO_W_C-1:0]      to_cnt_q, to_cnt_d;
  logic                   timeout_hit;

  assign timeout_hit = (TIMEOUT_G != 0) && (state_q == ACTIVE) && !data_valid_i &&
                       (to_cnt_q == TO_LAST_C);

  seq_rec_next_state #(
    .DATA_W_G   (DATA_W_G),
    .NUM_SEQ_G  (NUM_SEQ_G),
    .SEQ_LEN_G  (SEQ_LEN_G),
    .SEQ_TABLE_G(SEQ_TABLE_G),
    .IDLE_SYM_G (IDLE_SYM_G),
    .SEQ_W_G    (SEQ_W_C),
    .POS_W_G    (POS_W_C)
  ) u_next_state (
    .state_i      (state_q),
    .seq_id_i     (seq_id_q),
    .pos_i        (pos_q),
    .timeout_hit_i(timeout_hit),
    .data_i       (data_i),
    .valid_i      (data_valid_i),
    .state_d_o    (state_d),
    .seq_id_d_o   (seq_id_d),
    .pos_d_o      (pos_d)
  );

  always_comb begin
    to_cnt_d = '0;
    if ((TIMEOUT_G != 0) && (state_q == ACTIVE) && !data_valid_i && (state_d == ACTIVE)) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
    match_d = (state_d == DONE) && (state_q != DONE);
    // ERROR always leaves after one cycle, so every ERROR next-state is a fresh entry.
    err_cnt_d = err_cnt_q;
    if (clear_cnt_i) begin
      err_cnt_d = '0;
    end else if ((state_d == ERROR) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RESET_STATE_C;
      seq_id_q  <= '0;
      pos_q     <= '0;
      match_q   <= 1'b0;
      err_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      seq_id_q  <= seq_id_d;
      pos_q     <= pos_d;
      match_q   <= match_d;
      err_cnt_q <= err_cnt_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign state_o   = state_q;
  assign seq_id_o  = seq_id_q;
  assign pos_o     = pos_q;
  assign match_o   = match_q;
  assign error_o   = (state_q == ERROR);
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_seq_recognizer_fsm.sv
// Bench for seq_recognizer_fsm with default parameters: directed scenarios
// plus a randomized run against a symbol-level reference model.
module tb_seq_recognizer_fsm;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [2:0] data_i = '0;
  logic       data_valid_i = 1'b0;
  logic       clear_cnt_i = 1'b0;
  logic [1:0] state_o;
  logic [0:0] seq_id_o;
  logic [1:0] pos_o;
  logic       match_o;
  logic       error_o;
  logic [7:0] err_cnt_o;

  seq_recognizer_fsm dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .data_i      (data_i),
    .data_valid_i(data_valid_i),
    .clear_cnt_i (clear_cnt_i),
    .state_o     (state_o),
    .seq_id_o    (seq_id_o),
    .pos_o       (pos_o),
    .match_o     (match_o),
    .error_o     (error_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  localparam int TIMEOUT = 4;
  localparam int SEQ_LEN = 3;

  int checks = 0;
  int errors = 0;
  int tbl[2][3] = '{'{1, 2, 3}, '{4, 5, 6}};

  // Reference model: 0 idle, 1 in a sequence, 2 just finished, 3 error.
  int         m_state, m_id, m_pos, m_idle, m_cnt;
  bit         m_match;
  logic [0:0] exp_q[$];

  function automatic int hdr_idx(int d);
    for (int k = 0; k < 2; k++) if (tbl[k][0] == d) return k;
    return -1;
  endfunction

  task automatic model_update(bit v, int d, bit c, bit r);
    int nxt;
    if (r) begin
      m_state = 0; m_id = 0; m_pos = 0; m_idle = 0; m_cnt = 0; m_match = 0;
      exp_q.delete();
      return;
    end
    nxt = m_state;
    m_match = 0;
    case (m_state)
      0: if (v && hdr_idx(d) >= 0) begin nxt = 1; m_id = hdr_idx(d); m_pos = 1; end
      1: begin
        if (v) begin
          m_idle = 0;
          if (d == tbl[m_id][m_pos]) begin
            if (m_pos == SEQ_LEN - 1) begin
              nxt = 2; m_match = 1; m_pos = 0;
              exp_q.push_back(1'(m_id));
            end else m_pos++;
          end else begin
            nxt = 3; m_pos = 0;
          end
        end else begin
          m_idle++;
          if (m_idle == TIMEOUT) begin nxt = 3; m_pos = 0; end
        end
      end
      2: if (v) begin
        if (d == 0) nxt = 0;
        else if (hdr_idx(d) >= 0) begin nxt = 1; m_id = hdr_idx(d); m_pos = 1; end
        else nxt = 3;
      end
      default: nxt = 0;
    endcase
    if (nxt != 1) m_idle = 0;
    if (c) m_cnt = 0;
    else if (nxt == 3 && m_cnt < 255) m_cnt++;
    m_state = nxt;
  endtask

  task automatic step(bit v, int d, bit c = 0, bit r = 0);
    rst_i = r; data_valid_i = v; data_i = 3'(d); clear_cnt_i = c;
    @(posedge clk_i);
    model_update(v, d, c, r);
    #1;
  endtask

  task automatic test_reset();
    step(1, 4, 0, 1);
    step(0, 0, 0, 1);
    checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL reset_state got %0d exp 0", state_o); end
    checks++; if (seq_id_o !== 1'b0) begin errors++; $display("FAIL reset_seq_id got %0d exp 0", seq_id_o); end
    checks++; if (pos_o !== 2'd0) begin errors++; $display("FAIL reset_pos got %0d exp 0", pos_o); end
    checks++; if (match_o !== 1'b0 || error_o !== 1'b0) begin errors++; $display("FAIL reset_flags got match %0b error %0b exp 0 0", match_o, error_o); end
    checks++; if (err_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt_o); end
  endtask

  task automatic test_single_match();
    step(1, 1);
    checks++; if (state_o !== 2'b01 || pos_o !== 2'd1) begin errors++; $display("FAIL single_hdr got state %0d pos %0d exp 1 1", state_o, pos_o); end
    step(1, 2);
    step(1, 3);
    checks++; if (match_o !== 1'b1) begin errors++; $display("FAIL single_match got %0b exp 1", match_o); end
    checks++; if (seq_id_o !== 1'b0 || err_cnt_o !== 8'd0) begin errors++; $display("FAIL single_id got id %0d cnt %0d exp 0 0", seq_id_o, err_cnt_o); end
    step(0, 0);
    checks++; if (match_o !== 1'b0 || state_o !== 2'b10) begin errors++; $display("FAIL single_done_hold got match %0b state %0d exp 0 2", match_o, state_o); end
  endtask

  task automatic test_back_to_back();
    int syms[7] = '{4, 5, 6, 1, 2, 3, 0};
    logic [0:0] got[$];
    exp_q.delete();
    foreach (syms[i]) begin
      step(1, syms[i]);
      checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL b2b_no_error step %0d got %0b exp 0", i, error_o); end
      if (match_o) begin
        got.push_back(seq_id_o);
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_unexpected_match id %0d exp none", seq_id_o); end
        else begin
          logic [0:0] e;
          e = exp_q.pop_front();
          if (seq_id_o !== e) begin errors++; $display("FAIL b2b_match_id got %0d exp %0d", seq_id_o, e); end
        end
      end
    end
    checks++; if (got.size() != 2 || got[0] !== 1'b1 || got[1] !== 1'b0) begin errors++; $display("FAIL b2b_ids got %0d matches exp 2 (ids 1 then 0)", got.size()); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing_match got %0d pending exp 0", exp_q.size()); end
  endtask

  task automatic test_mismatch();
    step(0, 0, 0, 1);
    step(1, 4); step(1, 5); step(1, 2);
    checks++; if (error_o !== 1'b1 || state_o !== 2'b11) begin errors++; $display("FAIL mismatch_error got err %0b state %0d exp 1 3", error_o, state_o); end
    checks++; if (err_cnt_o !== 8'd1) begin errors++; $display("FAIL mismatch_cnt got %0d exp 1", err_cnt_o); end
    step(0, 0);
    checks++; if (error_o !== 1'b0 || state_o !== 2'b00) begin errors++; $display("FAIL mismatch_recover got err %0b state %0d exp 0 0", error_o, state_o); end
  endtask

  task automatic test_timeout();
    step(0, 0, 0, 1);
    step(1, 1);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      step(0, 0);
      checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL timeout_wait idle %0d got state %0d exp 1", i, state_o); end
    end
    step(0, 0);
    checks++; if (state_o !== 2'b11 || err_cnt_o !== 8'd1) begin errors++; $display("FAIL timeout_fire got state %0d cnt %0d exp 3 1", state_o, err_cnt_o); end
    step(0, 0);
    step(1, 1);
    for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0);
    step(1, 2); step(1, 3);
    checks++; if (match_o !== 1'b1 || error_o !== 1'b0 || err_cnt_o !== 8'd1) begin errors++; $display("FAIL timeout_just_under got match %0b err %0b cnt %0d exp 1 0 1", match_o, error_o, err_cnt_o); end
  endtask

  task automatic test_done_exit();
    step(0, 0, 0, 1);
    step(1, 1); step(1, 2); step(1, 3); step(1, 7);
    checks++; if (state_o !== 2'b11 || error_o !== 1'b1) begin errors++; $display("FAIL done_bad_sym got state %0d err %0b exp 3 1", state_o, error_o); end
    step(1, 1);
    checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL error_discard_hdr got state %0d exp 0", state_o); end
    step(1, 0); step(1, 7); step(1, 0);
    checks++; if (state_o !== 2'b00 || error_o !== 1'b0 || err_cnt_o !== 8'd1) begin errors++; $display("FAIL idle_junk got state %0d err %0b cnt %0d exp 0 0 1", state_o, error_o, err_cnt_o); end
  endtask

  task automatic test_saturation();
    step(0, 0, 0, 1);
    for (int i = 0; i < 256; i++) begin step(1, 1); step(1, 7); step(0, 0); end
    checks++; if (err_cnt_o !== 8'd255) begin errors++; $display("FAIL sat_reach got %0d exp 255", err_cnt_o); end
    step(1, 1); step(1, 7);
    checks++; if (err_cnt_o !== 8'd255 || error_o !== 1'b1) begin errors++; $display("FAIL sat_hold got cnt %0d err %0b exp 255 1", err_cnt_o, error_o); end
    step(0, 0);
    step(1, 1); step(1, 7, 1);
    checks++; if (err_cnt_o !== 8'd0 || error_o !== 1'b1) begin errors++; $display("FAIL clear_wins got cnt %0d err %0b exp 0 1", err_cnt_o, error_o); end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 0, 1);
    step(1, 4); step(1, 5);
    step(0, 0, 0, 1);
    checks++; if (state_o !== 2'b00 || pos_o !== 2'd0) begin errors++; $display("FAIL rst_mid got state %0d pos %0d exp 0 0", state_o, pos_o); end
    step(1, 6);
    checks++; if (state_o !== 2'b00 || match_o !== 1'b0 || error_o !== 1'b0) begin errors++; $display("FAIL rst_mid_tail got state %0d match %0b err %0b exp 0 0 0", state_o, match_o, error_o); end
  endtask

  task automatic test_random();
    step(0, 0, 0, 1);
    for (int n = 0; n < 3000; n++) begin
      bit v, c, r;
      int d;
      v = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1) d = (m_state == 1) ? tbl[m_id][m_pos] : tbl[$urandom_range(0, 1)][0];
      else d = $urandom_range(0, 7);
      c = ($urandom_range(0, 63) == 0);
      r = ($urandom_range(0, 255) == 0);
      step(v, d, c, r);
      checks++;
      if (state_o !== 2'(m_state) || seq_id_o !== 1'(m_id) || error_o !== (m_state == 3) ||
          err_cnt_o !== 8'(m_cnt) || match_o !== m_match) begin
        errors++;
        if (errors < 20) $display("FAIL rand_outputs cyc %0d got st %0d id %0d err %0b cnt %0d m %0b exp %0d %0d %0b %0d %0b",
                                  n, state_o, seq_id_o, error_o, err_cnt_o, match_o, m_state, m_id, m_state == 3, m_cnt, m_match);
      end
      if (m_state == 1) begin
        checks++;
        if (pos_o !== 2'(m_pos)) begin errors++; if (errors < 20) $display("FAIL rand_pos cyc %0d got %0d exp %0d", n, pos_o, m_pos); end
      end
      if (match_o && exp_q.size() != 0) begin
        logic [0:0] e;
        e = exp_q.pop_front();
        checks++;
        if (seq_id_o !== e) begin errors++; if (errors < 20) $display("FAIL rand_match_id cyc %0d got %0d exp %0d", n, seq_id_o, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_match();
    test_back_to_back();
    test_mismatch();
    test_timeout();
    test_done_exit();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
